// File: rtl/aud_pkg.sv
// Shared types and constants for the codec audio serialisers (player and recorder).
package aud_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } aud_state_e;

    localparam int MODE_I2S   = 1;
    localparam int MODE_LJ    = 0;

    localparam int DATA_W_MIN = 8;
    localparam int DATA_W_MAX = 32;

    // Width of a counter that must be able to hold the value w itself.
    function automatic int aud_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/aud_lrck_edge.sv
// LR clock edge detector: registers the codec LR clock and flags the cycle in
// which it changes, split into left-channel and right-channel slot starts.
module aud_lrck_edge #(
    parameter bit LEFT_LVL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lrck,
    output logic o_left_start,
    output logic o_right_start
);

    logic lrck_q;
    logic lrck_edge;

    // Previous-cycle copy of the LR clock; resets to the left level so a codec
    // already sitting on the left level does not look like a fresh frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_q <= LEFT_LVL;
        end else begin
            lrck_q <= i_lrck;
        end
    end

    assign lrck_edge     = (i_lrck != lrck_q);
    assign o_left_start  = lrck_edge && (i_lrck == LEFT_LVL);
    assign o_right_start = lrck_edge && (i_lrck != LEFT_LVL);

endmodule

// File: rtl/aud_player_i2s.sv
// Stereo DAC serialiser in the codec bit-clock domain: one-entry sample-pair
// buffer behind a valid/ready handshake, MSB-first shifting in I2S or
// left-justified framing, and underrun reporting.
// Optional build macro AUD_PLAYER_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun counter output o_underrun_cnt.
module aud_player_i2s #(
    parameter int DATA_W    = 16,
    parameter int I2S_DELAY = 1,
    parameter bit LEFT_LVL  = 1'b0
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_en,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    output logic              o_aud_dacdat,
    output logic              o_underrun
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       o_underrun_cnt
`endif
);

    import aud_pkg::*;

    localparam int CNT_W     = aud_cnt_w(DATA_W);
    localparam bit USE_DELAY = (I2S_DELAY == MODE_I2S);
    localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("aud_player_i2s: DATA_W must be within 8..32");
    end
    if (I2S_DELAY != MODE_I2S && I2S_DELAY != MODE_LJ) begin : g_bad_mode
        $error("aud_player_i2s: I2S_DELAY must be 0 or 1");
    end

    logic              left_start;
    logic              right_start;
    logic              slot_start;

    aud_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              chan_q, chan_d;

    logic [DATA_W-1:0] buf_l_q, buf_r_q;
    logic              buf_full_q, buf_full_d;
    logic              ready_q;
    logic [DATA_W-1:0] sh_l_q, sh_l_d;
    logic [DATA_W-1:0] sh_r_q, sh_r_d;

    logic              accept;
    logic              consume;
    logic [DATA_W-1:0] active_word;
    logic [CNT_W-1:0]  shift_amt;
    logic              emit_bit;

    logic              dat_q, dat_d;
    logic              underrun_q, underrun_d;

    aud_lrck_edge #(
        .LEFT_LVL(LEFT_LVL)
    ) u_lrck_edge (
        .i_clk        (i_bclk),
        .i_rst_n      (i_rst_n),
        .i_lrck       (i_daclrck),
        .o_left_start (left_start),
        .o_right_start(right_start)
    );

    // A right-channel edge only counts once the first left frame has begun.
    assign slot_start = left_start || (right_start && (state_q != IDLE));
    assign accept     = i_valid && ready_q;
    assign consume    = left_start && i_en && buf_full_q;

    // The bit about to be driven: the channel word selected for the coming
    // cycle, skipped past the bits already sent (none at a slot boundary).
    assign active_word = chan_d ? sh_r_d : sh_l_d;
    assign shift_amt   = slot_start ? '0 : cnt_q;
    assign emit_bit    = |(active_word & (MSB_MASK >> shift_amt));

    // Buffer fill flag and the shift-register reload taken at each frame start.
    always_comb begin
        buf_full_d = buf_full_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        if (consume) begin
            buf_full_d = 1'b0;
        end else if (accept) begin
            buf_full_d = 1'b1;
        end
        if (left_start) begin
            if (consume) begin
                sh_l_d = buf_l_q;
                sh_r_d = buf_r_q;
            end else begin
                sh_l_d = '0;
                sh_r_d = '0;
            end
        end
    end

    // Sample buffer, ready flag and channel shift registers.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b1;
            sh_l_q     <= '0;
            sh_r_q     <= '0;
        end else begin
            if (accept) begin
                buf_l_q <= i_left;
                buf_r_q <= i_right;
            end
            buf_full_q <= buf_full_d;
            ready_q    <= !buf_full_d;
            sh_l_q     <= sh_l_d;
            sh_r_q     <= sh_r_d;
        end
    end

    // Slot sequencer state, bit counter and active channel.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
        end
    end

    // Next state: every slot edge restarts the sequence; otherwise walk
    // DELAY -> SHIFT (DATA_W bits) -> PAD and wait for the next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        if (slot_start) begin
            chan_d = right_start;
            if (USE_DELAY) begin
                state_d = DELAY;
                cnt_d   = '0;
            end else begin
                state_d = SHIFT;
                cnt_d   = CNT_W'(1);
            end
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                DELAY: begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(1);
                end
                SHIFT: begin
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        state_d = PAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PAD:   state_d = PAD;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode for the next cycle's data bit and the underrun flag.
    always_comb begin
        dat_d      = 1'b0;
        underrun_d = left_start && i_en && !buf_full_q;
        if (slot_start) begin
            dat_d = USE_DELAY ? 1'b0 : emit_bit;
        end else begin
            case (state_q)
                DELAY:   dat_d = emit_bit;
                SHIFT:   dat_d = (cnt_q == CNT_W'(DATA_W)) ? 1'b0 : emit_bit;
                default: dat_d = 1'b0;
            endcase
        end
    end

    // Registered serial data and underrun pulse so the pins never glitch.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dat_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            dat_q      <= dat_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_aud_dacdat = dat_q;
    assign o_underrun   = underrun_q;

`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
    logic [15:0] und_cnt_q;

    // Saturating count of underrun pulses, cleared only by reset.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            und_cnt_q <= '0;
        end else if (underrun_q && (und_cnt_q != 16'hFFFF)) begin
            und_cnt_q <= und_cnt_q + 16'd1;
        end
    end

    assign o_underrun_cnt = und_cnt_q;
`else
    // Default build: underruns are only reported through the o_underrun pulse.
`endif

endmodule

// File: doc/aud_player_i2s.md
Name: aud_player_i2s

Overview:
- Parametrised stereo successor to the single-channel DAC serialiser. Runs entirely in the codec bit-clock domain.
- Accepts left/right sample pairs through a valid/ready handshake into a one-entry buffer, then shifts them MSB-first onto the codec DAC data pin, framed by the codec LR clock.
- Supports I2S (one-bit delay) and left-justified framing, any sample width 8..32, and underrun detection.
- Sits between the audio core (recorder/DSP output) and the WM8731 DAC pins.

Parameters:
- DATA_W, 16, sample width per channel in bits; legal range 8..32.
- I2S_DELAY, 1, 1 = I2S framing (MSB one bit clock after the LRCK edge); 0 = left-justified (MSB at the LRCK edge).
- LEFT_LVL, 0, i_daclrck level that denotes the left channel; the frame starts on the transition into this level.

Ports:
- i_bclk  in  1  codec bit clock, the only clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_daclrck  in  1  codec LR clock, synchronous to i_bclk.
- i_en  in  1  playback enable.
- i_valid  in  1  sample pair valid.
- o_ready  out  1  buffer empty, can accept a pair.
- i_left  in  DATA_W  left sample, two's complement.
- i_right  in  DATA_W  right sample, two's complement.
- o_aud_dacdat  out  1  serial DAC data.
- o_underrun  out  1  one-cycle pulse when a frame starts with no buffered pair while enabled.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; buffer empty; shift registers 0; lrck_q=LEFT_LVL.
  - Outputs: o_aud_dacdat=0, o_ready=1, o_underrun=0.
  - Reset mid-frame aborts the slot immediately; no partial data survives.
- Edge detect:
  - lrck_q is i_daclrck registered each cycle.
  - An edge is detected in a cycle where i_daclrck != lrck_q.
  - Left-start = edge into LEFT_LVL; right-start = the opposite edge.
- Handshake:
  - A pair is accepted when i_valid && o_ready; i_left/i_right are captured into the buffer that cycle.
  - o_ready is registered: 0 from the cycle after acceptance until the buffer is consumed.
  - Producers must hold i_valid and data stable until accepted.
- Frame start (left-start edge detected):
  - i_en=1 and buffer full: copy the pair into the L/R shift registers, empty the buffer (o_ready=1 next cycle).
  - i_en=1 and buffer empty: load zeros, pulse o_underrun for one cycle.
  - i_en=0: load zeros, no underrun pulse, buffer untouched.
  - Acceptance in the same cycle as frame start with the buffer empty: the new pair goes to the buffer and plays next frame; this frame counts as an underrun.
- Right-start edge: the right shift register becomes the active channel. Before the first left-start after reset, the block stays in IDLE and outputs 0.
- State machine:
  - IDLE: o_aud_dacdat=0. On left-start go to DELAY if I2S_DELAY=1, else SHIFT.
  - DELAY: one cycle, output 0, then SHIFT.
  - SHIFT: drive the active channel's MSB-first bit; the bit counter counts DATA_W bits, then go to PAD.
  - PAD: output 0 until the next LRCK edge.
  - Any LRCK edge in SHIFT/PAD/DELAY restarts at DELAY/SHIFT for the new channel. A slot shorter than DATA_W truncates the LSBs silently.
- Timing: with I2S_DELAY=0, the MSB appears on o_aud_dacdat after the rising edge that detects the LRCK edge. I2S_DELAY adds one bclk cycle.
- o_aud_dacdat is always a register output, never high-Z.
- Bit counter width is $clog2(DATA_W+1). Out-of-range DATA_W fails elaboration.

Optional Feature:
- Macro: AUD_PLAYER_UNDERRUN_CNT_EN.
- Defined: adds output o_underrun_cnt[15:0], which increments on each o_underrun pulse, saturates at 16'hFFFF, and clears only on reset.
- Undefined: the port and counter are absent; o_underrun pulse behaviour is identical.

Decomposition:
- Package aud_pkg:
  - state enum {IDLE, DELAY, SHIFT, PAD} (2-bit).
  - MODE_I2S=1 / MODE_LJ=0 constants.
  - DATA_W_MIN=8 / DATA_W_MAX=32.
- Sub-module aud_lrck_edge: the lrck_q register plus left-start/right-start pulse outputs. Reusable by the matching recorder.

Test Plan:
- DATA_W=16, I2S_DELAY=1, 32-bclk slots, pair L=16'hA5F0 R=16'h0F0F accepted before the left-start edge -> one 0 bit, then 1010010111110000, then 0s until the edge; right slot delay bit, then 0000111100001111; o_ready returns to 1 one cycle after frame start.
- I2S_DELAY=0, same pair -> MSB 1 on the cycle after edge detection; no zero lead bit.
- No i_valid before left-start with i_en=1 -> both slots all 0; o_underrun high exactly one cycle; cnt=1 with AUD_PLAYER_UNDERRUN_CNT_EN.
- i_en=0 with buffer full -> zeros output, no underrun, o_ready stays 0; set i_en=1 -> the buffered pair plays next frame.
- DATA_W=24 in 16-bclk slots, L=24'hFFFFFF -> 16 ones (with I2S_DELAY=1: delay bit then 15 ones), truncated at the edge; next slot starts cleanly.
- Assert i_rst_n=0 mid-SHIFT -> o_aud_dacdat=0 and o_ready=1 immediately (asynchronous); after release, output stays 0 until the next left-start.
